// File: rtl/integral_window_pkg.sv
// rtl/integral_window_pkg.sv - shared types and sizing helpers for the integral window buffer
package integral_window_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Column counter width for a given frame width
    function automatic int col_w(input int frame_w);
        return $clog2(frame_w);
    endfunction

    // Row counter width for a given frame height
    function automatic int row_w(input int frame_h);
        return $clog2(frame_h);
    endfunction

    // LSB of window element (c, r) in the flattened window bus; r=0 is the top row
    function automatic int win_lsb(input int c, input int r, input int win_w, input int integ_w);
        return (c + win_w * r) * integ_w;
    endfunction

endpackage

// File: rtl/integral_line_buffer.sv
// rtl/integral_line_buffer.sv - one integral row of storage, read-before-write at a shared address
module integral_line_buffer #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 20
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Combinational read returns the old entry, so a cascaded buffer receives it on the same edge
    assign rdata_o = mem_q[addr_i];

    // Write the new value at the same address on accepted pixels
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/integral_window_buffer.sv
// rtl/integral_window_buffer.sv - streaming integral image with WIN_W x WIN_H sliding window output
module integral_window_buffer
    import integral_window_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int INTEG_WIDTH = 20,
    parameter int FRAME_W     = 10,
    parameter int FRAME_H     = 10,
    parameter int WIN_W       = 3,
    parameter int WIN_H       = 3
) (
    input  logic                                 clk_os,
    input  logic                                 reset_os,
    input  logic [PIXEL_WIDTH-1:0]               i_pixel,
    input  logic                                 i_pixel_valid,
    input  logic                                 i_sof,
    output logic [WIN_W*WIN_H*INTEG_WIDTH-1:0]   o_window,
    output logic                                 o_window_valid,
    output logic [$clog2(FRAME_W)-1:0]           o_window_x,
    output logic [$clog2(FRAME_H)-1:0]           o_window_y,
    output logic                                 o_frame_done,
    output logic                                 o_sof_error
);

    localparam int COL_W = col_w(FRAME_W);
    localparam int ROW_W = row_w(FRAME_H);
    localparam int NLB   = WIN_H - 1;
    localparam int IW    = INTEG_WIDTH;

    state_t                              state_q;
    logic [COL_W-1:0]                    col_q;
    logic [ROW_W-1:0]                    row_q;
    logic [IW-1:0]                       rowsum_q;
    logic [WIN_H-1:0][WIN_W-1:0][IW-1:0] win_q;
    logic                                valid_q;
    logic [COL_W-1:0]                    x_q;
    logic [ROW_W-1:0]                    y_q;
    logic                                done_q;
    logic                                err_q;

    logic                                proc;
    logic [COL_W-1:0]                    cur_col;
    logic [ROW_W-1:0]                    cur_row;
    logic                                last_col;
    logic                                last_pix;
    logic                                emit;
    logic [IW-1:0]                       rowsum_d;
    logic [IW-1:0]                       integ;
    logic [NLB-1:0][IW-1:0]              lb_rd;
    logic [NLB-1:0][IW-1:0]              lb_wr;
    logic [WIN_H-1:0][IW-1:0]            feed;

    // A pixel is processed when a frame is running or when it starts one; i_sof always restarts at (0,0)
    always_comb begin
        proc     = i_pixel_valid && ((state_q == ST_ACTIVE) || i_sof);
        cur_col  = i_sof ? '0 : col_q;
        cur_row  = i_sof ? '0 : row_q;
        last_col = (cur_col == COL_W'(FRAME_W - 1));
        last_pix = last_col && (cur_row == ROW_W'(FRAME_H - 1));
        emit     = proc && (cur_col >= COL_W'(WIN_W - 1)) && (cur_row >= ROW_W'(WIN_H - 1));
        rowsum_d = ((cur_col == '0) ? '0 : rowsum_q) + IW'(i_pixel);
        integ    = rowsum_d + ((cur_row == '0) ? '0 : lb_rd[0]);
    end

    // Buffer 0 holds row-1 and receives the fresh integral; deeper buffers take the previous buffer's old entry
    for (genvar k = 0; k < NLB; k++) begin : g_lb
        if (k == 0) begin : g_first
            assign lb_wr[k] = integ;
        end else begin : g_cascade
            assign lb_wr[k] = lb_rd[k-1];
        end
        integral_line_buffer #(
            .DEPTH (FRAME_W),
            .WIDTH (IW)
        ) u_lb (
            .clk_i   (clk_os),
            .we_i    (proc),
            .addr_i  (cur_col),
            .wdata_i (lb_wr[k]),
            .rdata_o (lb_rd[k])
        );
    end

    // Bottom window row takes the current integral, row r above it takes the value WIN_H-1-r rows back
    for (genvar r = 0; r < WIN_H; r++) begin : g_feed
        if (r == WIN_H - 1) begin : g_bottom
            assign feed[r] = integ;
        end else begin : g_upper
            assign feed[r] = lb_rd[WIN_H-2-r];
        end
    end

    // Frame FSM, position counters, running row sum and registered pulse outputs
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            rowsum_q <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= proc && last_pix;
            err_q   <= i_pixel_valid && i_sof && (state_q == ST_ACTIVE);
            if (emit) begin
                x_q <= cur_col - COL_W'(WIN_W - 1);
                y_q <= cur_row - ROW_W'(WIN_H - 1);
            end
            if (proc) begin
                rowsum_q <= rowsum_d;
                if (last_pix) begin
                    state_q <= ST_IDLE;
                    col_q   <= '0;
                    row_q   <= '0;
                end else begin
                    state_q <= ST_ACTIVE;
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= cur_row + ROW_W'(1);
                    end else begin
                        col_q <= cur_col + COL_W'(1);
                        row_q <= cur_row;
                    end
                end
            end
        end
    end

    // Window shift registers: newest column enters at c=WIN_W-1, only on processed pixels
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            win_q <= '0;
        end else if (proc) begin
            for (int r = 0; r < WIN_H; r++) begin
                win_q[r] <= {feed[r], win_q[r][WIN_W-1:1]};
            end
        end
    end

    for (genvar r = 0; r < WIN_H; r++) begin : g_out_r
        for (genvar c = 0; c < WIN_W; c++) begin : g_out_c
            assign o_window[win_lsb(c, r, WIN_W, IW) +: IW] = win_q[r][c];
        end
    end

    assign o_window_valid = valid_q;
    assign o_window_x     = x_q;
    assign o_window_y     = y_q;
    assign o_frame_done   = done_q;
    assign o_sof_error    = err_q;

endmodule

// File: doc/integral_window_buffer.md
# integral_window_buffer

Streaming integral-image generator and sliding-window buffer for the face detection pipeline. Accepts camera pixels in raster order, computes the running integral image of each frame on the fly, and keeps the last WIN_H integral rows in line buffers. Every time a full WIN_W×WIN_H window of integral values is available, it presents that window with its coordinates to the Haar classifier stage. It supersedes the fixed 3×3, free-running integral memory by adding:

- frame framing,
- valid-qualified input with gaps,
- generic window and frame size,
- window position output.

## Interface
- PIXEL_WIDTH, 8, input pixel width.
- INTEG_WIDTH, 20, integral value width. Arithmetic is modulo 2^INTEG_WIDTH.
- FRAME_W, 10, pixels per line (≥ WIN_W).
- FRAME_H, 10, lines per frame (≥ WIN_H).
- WIN_W, 3, window width (≥ 2).
- WIN_H, 3, window height (≥ 2).
- clk_os  in  1  sole clock.
- reset_os  in  1  synchronous, active-high reset.
- i_pixel  in  PIXEL_WIDTH  pixel value.
- i_pixel_valid  in  1  pixel accepted this cycle.
- i_sof  in  1  start of frame, qualified by i_pixel_valid. Marks pixel (0,0).
- o_window  out  WIN_W*WIN_H*INTEG_WIDTH  flattened window. Element idx = c + WIN_W*r, where r=0 is the top row and c=0 the left column. The element occupies bits [(idx+1)*INTEG_WIDTH-1 : idx*INTEG_WIDTH].
- o_window_valid  out  1  o_window, o_window_x and o_window_y are valid this cycle.
- o_window_x  out  $clog2(FRAME_W)  top-left column of the window.
- o_window_y  out  $clog2(FRAME_H)  top-left row of the window.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- o_sof_error  out  1  one-cycle pulse when i_sof arrives mid-frame.

## Operation
- States:
  - IDLE: accepted pixels without i_sof are discarded. An accepted i_sof pixel moves the block to ACTIVE, and that pixel is processed as (0,0).
  - ACTIVE: each accepted pixel advances col (0..FRAME_W-1) and then row (0..FRAME_H-1). After pixel (FRAME_W-1, FRAME_H-1) the block returns to IDLE and o_frame_done pulses.
- Integral computation:
  - rowsum = (col==0 ? 0 : rowsum) + pixel.
  - I(col,row) = rowsum + (row==0 ? 0 : I(col,row-1)), where I(col,row-1) is read from line buffer 0.
  - Pixels are zero-extended to INTEG_WIDTH.
  - Sums wrap modulo 2^INTEG_WIDTH. No saturation.
- Line buffers: WIN_H-1 buffers of FRAME_W entries hold integral rows row-1 … row-WIN_H+1.
  - Each is read-before-write at address col, so buffer k's output cascades into buffer k+1.
  - Contents are don't-care until written in the current frame. Rows with row-k < 0 are never used for window output.
- Window registers: one WIN_W-deep shift register per window row, shifted only on accepted pixels.
  - The bottom row is fed by I(col,row).
  - Upper rows are fed by the line buffer outputs.
- Window emission: on acceptance of pixel (col,row) with col ≥ WIN_W-1 and row ≥ WIN_H-1, a window is emitted with:
  - o_window_x = col-WIN_W+1
  - o_window_y = row-WIN_H+1
  - The window never spans a line wrap.
- Windows per frame: (FRAME_W-WIN_W+1)*(FRAME_H-WIN_H+1).
- i_sof with valid while ACTIVE:
  - The current frame is aborted and o_sof_error pulses.
  - The pixel is processed as (0,0) of a new frame.
  - No o_frame_done is generated for the aborted frame.
- i_sof and the last pixel of a frame cannot coincide, because they are the same accepted beat. i_sof wins and is treated as a new frame, which counts as an abort.

## Timing
- Latency: o_window_valid is high exactly 1 cycle after the accepting edge of the completing pixel. It is one cycle wide per window.
- Gaps in i_pixel_valid freeze all state. Outputs hold their values, but o_window_valid is low.
- Back-to-back valid pixels give one window per cycle. There is no backpressure; the block accepts every valid beat.
- o_frame_done is asserted 1 cycle after the last pixel. For that pixel's window, o_frame_done and o_window_valid are high in the same cycle.
- Reset:
  - All outputs go to 0.
  - State goes to IDLE; counters and rowsum clear.
  - Reset mid-frame discards the frame with no pulses.
  - Line buffer contents need not be cleared.

## Structure
- Package integral_window_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - the localparams COL_W = $clog2(FRAME_W) and ROW_W = $clog2(FRAME_H), provided as functions of the parameters;
  - a helper function for flat-window slice indexing.
- Sub-module integral_line_buffer: a single FRAME_W×INTEG_WIDTH read-before-write RAM with write enable, instantiated WIN_H-1 times.

## Test plan
- FRAME 6×4, WIN 3×3, all pixels 1, continuous valid:
  - First window 1 cycle after pixel (2,2), at x=0, y=0, containing {1,2,3, 2,4,6, 3,6,9}.
  - 8 windows total; the last is at (3,1) with its bottom-right value 24.
  - o_frame_done pulses with the last window.
- Same frame with i_pixel_valid toggled 1-0-0-1 pseudo-randomly: identical window sequence and values, with no window emitted during gaps.
- Pixels sent in IDLE without i_sof: no windows. A following i_sof frame behaves exactly as in the first scenario.
- i_sof at pixel (4,2) of a frame: o_sof_error pulses, then a full 8-window frame follows from the restart, with no o_frame_done for the aborted frame.
- INTEG_WIDTH=8, all pixels 255: I(1,0)=254 and I(2,2)=255*9 mod 256=247 appear in the first window.
- reset_os asserted mid-frame for 1 cycle: all outputs are 0 the next cycle, no windows appear until a new i_sof, and that frame matches the first scenario.
